// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants used by
// both the receive and transmit paths.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS          = 8;
  localparam int STOP_BITS          = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input pin; both flops reset to
// RESET_VAL so an idle-high line does not look like an edge after reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_50m,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, giving a true two-stage pipeline.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start detection, 2-of-3 majority vote per bit,
// sticky rdy/overrun flags cleared by rdy_clr, one-cycle frame_err pulse.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk_50m,
  input  logic       reset_n,
  input  logic       clken,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] data,
  output logic       rdy,
  output logic       overrun,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [SW-1:0] SC_LO    = SW'(MID - 2);
  localparam logic [SW-1:0] SC_CTR   = SW'(MID - 1);
  localparam logic [SW-1:0] SC_HI    = SW'(MID);
  localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [SW-1:0]        scnt_q;
  logic [BW-1:0]        bitpos_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [2:0]           samp_q;
  logic [7:0]           data_q;
  logic                 rdy_q;
  logic                 overrun_q;
  logic                 frame_err_q;

  logic rx_s;
  logic data_vote;
  logic stop_vote;
  logic byte_done;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk_50m (clk_50m),
    .reset_n (reset_n),
    .async_i (rx),
    .sync_o  (rx_s)
  );

  // The stop decision is taken on the third sample tick itself, so the live
  // rx_s stands in for the third stored sample.
  assign data_vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign stop_vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign byte_done = clken && (state_q == ST_STOP) && (scnt_q == SC_HI) && stop_vote;

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the shift register and sample flops are reset along with the
      // control state so an abandoned frame leaves nothing behind.
      state_q     <= ST_IDLE;
      scnt_q      <= '0;
      bitpos_q    <= '0;
      shreg_q     <= '0;
      samp_q      <= '1;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;

      if (rdy_clr) begin
        rdy_q <= 1'b0;
        if (!byte_done) overrun_q <= 1'b0;
      end

      if (clken) begin
        if (state_q == ST_DATA || state_q == ST_STOP) begin
          if (scnt_q == SC_LO)  samp_q[0] <= rx_s;
          if (scnt_q == SC_CTR) samp_q[1] <= rx_s;
          if (scnt_q == SC_HI)  samp_q[2] <= rx_s;
        end

        case (state_q)
          ST_IDLE: begin
            if (!rx_s) begin
              state_q  <= ST_START;
              scnt_q   <= '0;
              bitpos_q <= '0;
            end
          end

          // Start bit is confirmed at its centre, then counted out to its end
          // so DATA windows start on bit boundaries and samples land mid-bit.
          ST_START: begin
            if (scnt_q == SC_CTR && rx_s) begin
              state_q <= ST_IDLE;
            end else if (scnt_q == SC_LAST) begin
              scnt_q  <= '0;
              state_q <= ST_DATA;
            end else begin
              scnt_q <= scnt_q + SW'(1);
            end
          end

          ST_DATA: begin
            if (scnt_q == SC_LAST) begin
              shreg_q[bitpos_q] <= data_vote;
              scnt_q            <= '0;
              if (bitpos_q == LAST_BIT) state_q <= ST_STOP;
              else                      bitpos_q <= bitpos_q + BW'(1);
            end else begin
              scnt_q <= scnt_q + SW'(1);
            end
          end

          ST_STOP: begin
            if (scnt_q == SC_HI) begin
              state_q <= ST_IDLE;
              if (stop_vote) begin
                data_q <= shreg_q;
                rdy_q  <= 1'b1;
                if (rdy_q && !rdy_clr) overrun_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              scnt_q <= scnt_q + SW'(1);
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: serial frames are generated at the
// bit level and results compared with a byte-level model of the flags.
module tb_uart_receiver;

  localparam int OS = 16;
  localparam int CK = 4;

  logic       clk_50m = 1'b0;
  logic       reset_n = 1'b0;
  logic       clken   = 1'b0;
  logic       rx      = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       rdy;
  logic       overrun;
  logic       frame_err;
  logic       rx_busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_data = 8'h00;
  logic       exp_rdy  = 1'b0;
  logic       exp_ovr  = 1'b0;
  int         exp_fe   = 0;
  int         fe_seen  = 0;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .clk_50m   (clk_50m),
    .reset_n   (reset_n),
    .clken     (clken),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .overrun   (overrun),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk_50m = ~clk_50m;

  initial begin : clken_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk_50m);
      div   = (div + 1) % CK;
      clken = (div == 0);
    end
  end

  // Counts cycles with frame_err high; each bad frame must add exactly one.
  always @(negedge clk_50m) if (frame_err) fe_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50m);
      while (clken !== 1'b1) @(posedge clk_50m);
    end
  endtask

  task automatic drive_bit(input logic b, input int glitch_at);
    @(negedge clk_50m);
    rx = b;
    if (glitch_at >= 0) begin
      wait_ticks(glitch_at);
      @(negedge clk_50m);
      rx = ~b;
      wait_ticks(1);
      @(negedge clk_50m);
      rx = b;
      wait_ticks(OS - glitch_at - 1);
    end else begin
      wait_ticks(OS);
    end
  endtask

  // Sends one 8N1 frame and applies its effect to the model.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
    wait_ticks(1);
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(b[i], (i == glitch_bit) ? OS / 2 : -1);
    drive_bit(stop, -1);
    @(negedge clk_50m);
    rx = 1'b1;
    if (stop) begin
      exp_ovr  = exp_ovr | exp_rdy;
      exp_rdy  = 1'b1;
      exp_data = b;
    end else begin
      exp_fe++;
      wait_ticks(2 * OS);
      @(negedge clk_50m);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m);
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
    exp_rdy = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_50m);
    checks++; if (data !== 8'h00)    begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (rdy !== 1'b0)      begin errors++; $display("FAIL reset_rdy: got %b want 0", rdy); end
    checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (rx_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    reset_n = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_start_glitch();
    wait_ticks(1);
    @(negedge clk_50m);
    rx = 1'b0;
    wait_ticks(4);
    @(negedge clk_50m);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during: got %b want 1", rx_busy); end
    rx = 1'b1;
    wait_ticks(OS);
    @(negedge clk_50m);
    checks++; if (rx_busy !== 1'b0)  begin errors++; $display("FAIL glitch_busy_after: got %b want 0", rx_busy); end
    checks++; if (rdy !== exp_rdy)   begin errors++; $display("FAIL glitch_rdy: got %b want %b", rdy, exp_rdy); end
    checks++; if (data !== exp_data) begin errors++; $display("FAIL glitch_data: got %h want %h", data, exp_data); end
    checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL glitch_frame_err: got %0d want %0d", fe_seen, exp_fe); end
  endtask

  task automatic test_nominal();
    send_frame(8'h55, 1'b1, -1);
    checks++; if (data !== 8'h55)     begin errors++; $display("FAIL nominal_data: got %h want 55", data); end
    checks++; if (rdy !== 1'b1)       begin errors++; $display("FAIL nominal_rdy: got %b want 1", rdy); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL nominal_overrun: got %b want 0", overrun); end
    checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL nominal_frame_err: got %0d want %0d", fe_seen, exp_fe); end
    checks++; if (rx_busy !== 1'b0)   begin errors++; $display("FAIL nominal_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_bad_stop();
    pulse_clr();
    @(negedge clk_50m);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL clear_rdy: got %b want 0", rdy); end
    send_frame(8'hA3, 1'b0, -1);
    checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL badstop_frame_err: got %0d cycles want %0d", fe_seen, exp_fe); end
    checks++; if (rdy !== 1'b0)       begin errors++; $display("FAIL badstop_rdy: got %b want 0", rdy); end
    checks++; if (data !== 8'h55)     begin errors++; $display("FAIL badstop_data: got %h want 55", data); end
  endtask

  task automatic test_overrun();
    send_frame(8'h12, 1'b1, -1);
    send_frame(8'h34, 1'b1, -1);
    checks++; if (data !== 8'h34)    begin errors++; $display("FAIL overrun_data: got %h want 34", data); end
    checks++; if (rdy !== 1'b1)      begin errors++; $display("FAIL overrun_rdy: got %b want 1", rdy); end
    checks++; if (overrun !== 1'b1)  begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun); end
    pulse_clr();
    @(negedge clk_50m);
    checks++; if (rdy !== 1'b0)      begin errors++; $display("FAIL overrun_clr_rdy: got %b want 0", rdy); end
    checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL overrun_clr_flag: got %b want 0", overrun); end
    checks++; if (data !== 8'h34)    begin errors++; $display("FAIL overrun_clr_data: got %h want 34", data); end
  endtask

  task automatic test_noise();
    send_frame(8'hF0, 1'b1, 4);
    checks++; if (data !== 8'hF0)   begin errors++; $display("FAIL noise_data: got %h want f0", data); end
    checks++; if (rdy !== 1'b1)     begin errors++; $display("FAIL noise_rdy: got %b want 1", rdy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL noise_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h5A;
    wait_ticks(1);
    drive_bit(1'b0, -1);
    for (int i = 0; i < 3; i++) drive_bit(b[i], -1);
    @(negedge clk_50m);
    rx = b[3];
    wait_ticks(OS / 2);
    @(negedge clk_50m);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b want 1", rx_busy); end
    reset_n = 1'b0;
    rx      = 1'b1;
    #1;
    checks++; if (data !== 8'h00)     begin errors++; $display("FAIL midreset_data: got %h want 00", data); end
    checks++; if (rdy !== 1'b0)       begin errors++; $display("FAIL midreset_rdy: got %b want 0", rdy); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL midreset_overrun: got %b want 0", overrun); end
    checks++; if (rx_busy !== 1'b0)   begin errors++; $display("FAIL midreset_busy: got %b want 0", rx_busy); end
    exp_data = 8'h00;
    exp_rdy  = 1'b0;
    exp_ovr  = 1'b0;
    repeat (3) @(negedge clk_50m);
    reset_n = 1'b1;
    wait_ticks(4);
    send_frame(8'hC9, 1'b1, -1);
    checks++; if (data !== 8'hC9)     begin errors++; $display("FAIL midreset_next_data: got %h want c9", data); end
    checks++; if (rdy !== 1'b1)       begin errors++; $display("FAIL midreset_next_rdy: got %b want 1", rdy); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL midreset_next_overrun: got %b want 0", overrun); end
    checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL midreset_frame_err: got %0d want %0d", fe_seen, exp_fe); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 2) == 0) pulse_clr();
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, -1);
      checks++; if (data !== exp_data)   begin errors++; $display("FAIL rand%0d_data: got %h want %h", n, data, exp_data); end
      checks++; if (rdy !== exp_rdy)     begin errors++; $display("FAIL rand%0d_rdy: got %b want %b", n, rdy, exp_rdy); end
      checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL rand%0d_overrun: got %b want %b", n, overrun, exp_ovr); end
      checks++; if (fe_seen !== exp_fe)  begin errors++; $display("FAIL rand%0d_frame_err: got %0d want %0d", n, fe_seen, exp_fe); end
    end
  endtask

  initial begin
    test_reset();
    test_start_glitch();
    test_nominal();
    test_bad_stop();
    test_overrun();
    test_noise();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
